uart_reg_bridge: RTL

//  Second-generation UART-to-register-bank bridge. Drives the same reg_en/reg_we bus as the I2C bridge.

---
 rtl/uart_reg_bridge.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: UART (8N1) command parser driving a reg_en/reg_we register bus.
// Commands: W/w addr data, R/r addr, B addr len data*len, b addr len. Multi-byte fields go MSB first.
// Optional feature macro: UART_ACK_EN queues ACK 0x06 after writes and NAK 0x15 on aborted frames.
module uart_reg_bridge #(
  parameter int unsigned CLK_FREQ   = 27000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned ADDR_BYTES = 1,
  parameter int unsigned DATA_BYTES = 1,
  parameter int unsigned TXF_DEPTH  = 16,
  parameter int unsigned TIMEOUT_BT = 20
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      uart_rx,
  output logic                      uart_tx,
  output logic [8*ADDR_BYTES-1:0]   reg_addr,
  output logic [8*DATA_BYTES-1:0]   reg_wdata,
  input  logic [8*DATA_BYTES-1:0]   reg_rdata,
  output logic                      reg_en,
  output logic                      reg_we,
  output logic                      rx_frame_err,
  output logic                      busy
);

  localparam int unsigned BIT_T  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_T = BIT_T / 2;
  localparam int unsigned AW     = 8 * ADDR_BYTES;
  localparam int unsigned DW     = 8 * DATA_BYTES;
  localparam int unsigned CW     = $clog2(BIT_T + 1);
  localparam int unsigned PW     = $clog2(TXF_DEPTH);
  localparam int unsigned PTRW   = PW + 1;
  localparam int unsigned TO_CYC = TIMEOUT_BT * BIT_T;
  localparam int unsigned TW     = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_LEN, P_WDATA, P_RD_ISSUE, P_RD_CAP} p_state_t;

  // RX path registers
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t       rx_st_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_sh_q;
  logic            rx_valid_q, rx_ferr_q;

  // Parser registers
  p_state_t        p_st_q;
  logic            is_wr_q, is_blk_q, cap_ph_q;
  logic [AW-1:0]   addr_q, reg_addr_q;
  logic [DW-1:0]   wdata_q, reg_wdata_q;
  logic [8:0]      len_q;
  logic [2:0]      bidx_q;
  logic [TW-1:0]   to_cnt_q;
  logic            reg_en_q, reg_we_q;

  // TX FIFO and shifter
  logic [7:0]      txf_mem_q [TXF_DEPTH];
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
  logic            tx_act_q, uart_tx_q, busy_q;
  logic [CW-1:0]   tx_cnt_q;
  logic [3:0]      tx_bit_q;
  logic [9:0]      tx_sh_q;

  logic [PTRW-1:0] fifo_cnt_c, fifo_free_c;
  logic            fifo_empty_c, fifo_full_c, in_frame_c, timed_out_c, tx_load_c, wr_done_c;
  logic            ack_push_c;
  logic [7:0]      ack_byte_c;

  assign fifo_cnt_c   = wr_ptr_q - rd_ptr_q;
  assign fifo_free_c  = PTRW'(TXF_DEPTH) - fifo_cnt_c;
  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c  = (fifo_cnt_c == PTRW'(TXF_DEPTH));
  assign in_frame_c   = (p_st_q == P_ADDR) || (p_st_q == P_LEN) || (p_st_q == P_WDATA);
  assign timed_out_c  = in_frame_c && !rx_valid_q && (to_cnt_q == TW'(TO_CYC - 1));
  assign wr_done_c    = (p_st_q == P_WDATA) && rx_valid_q &&
                        (bidx_q == 3'(DATA_BYTES - 1)) && (len_q == 9'd1);
  assign tx_load_c    = !fifo_empty_c &&
                        (!tx_act_q || (tx_cnt_q == CW'(BIT_T - 1) && tx_bit_q == 4'd9));

  assign uart_tx      = uart_tx_q;
  assign reg_addr     = reg_addr_q;
  assign reg_wdata    = reg_wdata_q;
  assign reg_en       = reg_en_q;
  assign reg_we       = reg_we_q;
  assign rx_frame_err = rx_ferr_q;
  assign busy         = busy_q;

`ifdef UART_ACK_EN
  // Select the ACK/NAK byte to queue this cycle; a full FIFO drops it
  always_comb begin
    ack_push_c = 1'b0;
    ack_byte_c = 8'h06;
    if (rx_ferr_q && p_st_q != P_IDLE) begin
      ack_push_c = 1'b1;
      ack_byte_c = 8'h15;
    end else if (timed_out_c) begin
      ack_push_c = 1'b1;
      ack_byte_c = 8'h15;
    end else if (wr_done_c) begin
      ack_push_c = 1'b1;
    end
    if (fifo_full_c) ack_push_c = 1'b0;
  end
`else
  assign ack_push_c = 1'b0;
  assign ack_byte_c = 8'h00;
`endif

  // Synchronise uart_rx and deserialise 8N1 bytes, sampling mid-bit
  always_ff @(posedge clk) begin
    if (!resetb) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_st_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_st_q  <= RX_START;
            rx_cnt_q <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == CW'(HALF_T - 1)) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == CW'(BIT_T - 1)) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: begin
          if (rx_cnt_q == CW'(BIT_T - 1)) begin
            rx_cnt_q <= '0;
            rx_st_q  <= RX_IDLE;
            if (rx_s2_q) rx_valid_q <= 1'b1;
            else         rx_ferr_q  <= 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Command parser: register strobes, read capture into the TX FIFO, timeout and abort
  always_ff @(posedge clk) begin
    if (!resetb) begin
      p_st_q      <= P_IDLE;
      is_wr_q     <= 1'b0;
      is_blk_q    <= 1'b0;
      cap_ph_q    <= 1'b0;
      addr_q      <= '0;
      reg_addr_q  <= '0;
      wdata_q     <= '0;
      reg_wdata_q <= '0;
      len_q       <= 9'd1;
      bidx_q      <= '0;
      to_cnt_q    <= '0;
      reg_en_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      wr_ptr_q    <= '0;
    end else begin
      reg_en_q <= 1'b0;
      reg_we_q <= 1'b0;
      if (rx_valid_q || !in_frame_c) to_cnt_q <= '0;
      else                           to_cnt_q <= to_cnt_q + TW'(1);

      if (rx_ferr_q && p_st_q != P_IDLE) begin
        p_st_q <= P_IDLE;
      end else if (timed_out_c) begin
        p_st_q <= P_IDLE;
      end else begin
        case (p_st_q)
          P_IDLE: begin
            if (rx_valid_q) begin
              bidx_q <= '0;
              addr_q <= '0;
              len_q  <= 9'd1;
              case (rx_sh_q)
                8'h57, 8'h77: begin is_wr_q <= 1'b1; is_blk_q <= 1'b0; p_st_q <= P_ADDR; end
                8'h52, 8'h72: begin is_wr_q <= 1'b0; is_blk_q <= 1'b0; p_st_q <= P_ADDR; end
                8'h42:        begin is_wr_q <= 1'b1; is_blk_q <= 1'b1; p_st_q <= P_ADDR; end
                8'h62:        begin is_wr_q <= 1'b0; is_blk_q <= 1'b1; p_st_q <= P_ADDR; end
                default: ;
              endcase
            end
          end
          P_ADDR: begin
            if (rx_valid_q) begin
              addr_q <= AW'({addr_q, rx_sh_q});
              if (bidx_q == 3'(ADDR_BYTES - 1)) begin
                bidx_q <= '0;
                if (is_blk_q)     p_st_q <= P_LEN;
                else if (is_wr_q) p_st_q <= P_WDATA;
                else              p_st_q <= P_RD_ISSUE;
              end else begin
                bidx_q <= bidx_q + 3'd1;
              end
            end
          end
          P_LEN: begin
            if (rx_valid_q) begin
              len_q  <= (rx_sh_q == 8'h00) ? 9'd256 : {1'b0, rx_sh_q};
              p_st_q <= is_wr_q ? P_WDATA : P_RD_ISSUE;
            end
          end
          P_WDATA: begin
            if (rx_valid_q) begin
              wdata_q <= DW'({wdata_q, rx_sh_q});
              if (bidx_q == 3'(DATA_BYTES - 1)) begin
                reg_en_q    <= 1'b1;
                reg_we_q    <= 1'b1;
                reg_addr_q  <= addr_q;
                reg_wdata_q <= DW'({wdata_q, rx_sh_q});
                addr_q      <= addr_q + AW'(1);
                len_q       <= len_q - 9'd1;
                bidx_q      <= '0;
                if (len_q == 9'd1) p_st_q <= P_IDLE;
              end else begin
                bidx_q <= bidx_q + 3'd1;
              end
            end
          end
          P_RD_ISSUE: begin
            if (fifo_free_c >= PTRW'(DATA_BYTES)) begin
              reg_en_q   <= 1'b1;
              reg_addr_q <= addr_q;
              cap_ph_q   <= 1'b0;
              p_st_q     <= P_RD_CAP;
            end
          end
          default: begin
            // First cycle is the strobe itself; read data is valid one cycle later
            if (!cap_ph_q) begin
              cap_ph_q <= 1'b1;
            end else begin
              for (int i = 0; i < int'(DATA_BYTES); i++) begin
                txf_mem_q[wr_ptr_q[PW-1:0] + PW'(i)] <= reg_rdata[DW-1-8*i -: 8];
              end
              wr_ptr_q <= wr_ptr_q + PTRW'(DATA_BYTES);
              addr_q   <= addr_q + AW'(1);
              len_q    <= len_q - 9'd1;
              p_st_q   <= (len_q == 9'd1) ? P_IDLE : P_RD_ISSUE;
            end
          end
        endcase
      end

      if (ack_push_c) begin
        txf_mem_q[wr_ptr_q[PW-1:0]] <= ack_byte_c;
        wr_ptr_q <= wr_ptr_q + PTRW'(1);
      end
    end
  end

  // TX shifter: pops the FIFO and sends back-to-back 8N1 frames; also derives busy
  always_ff @(posedge clk) begin
    if (!resetb) begin
      uart_tx_q <= 1'b1;
      tx_act_q  <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
      rd_ptr_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= (p_st_q != P_IDLE) || !fifo_empty_c || tx_act_q;
      if (tx_load_c) begin
        tx_sh_q   <= {1'b1, txf_mem_q[rd_ptr_q[PW-1:0]], 1'b0};
        uart_tx_q <= 1'b0;
        tx_act_q  <= 1'b1;
        tx_cnt_q  <= '0;
        tx_bit_q  <= '0;
        rd_ptr_q  <= rd_ptr_q + PTRW'(1);
      end else if (tx_act_q) begin
        if (tx_cnt_q == CW'(BIT_T - 1)) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 4'd9) begin
            tx_act_q  <= 1'b0;
            uart_tx_q <= 1'b1;
          end else begin
            tx_bit_q  <= tx_bit_q + 4'd1;
            tx_sh_q   <= {1'b1, tx_sh_q[9:1]};
            uart_tx_q <= tx_sh_q[1];
          end
        end else begin
          tx_cnt_q <= tx_cnt_q + CW'(1);
        end
      end
    end
  end

endmodule
